// File: rtl/draw_cursor_if.sv
// vga_if: VGA timing and pixel bundle passed between draw stages.
interface vga_if;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] vcount;
  logic [11:0] hcount;
  logic [11:0] rgb;
  modport in  (input  vsync, hsync, vblnk, hblnk, vcount, hcount, rgb);
  modport out (output vsync, hsync, vblnk, hblnk, vcount, hcount, rgb);
endinterface

// File: rtl/draw_cursor.sv
// draw_cursor: 2-bpp sprite cursor overlay with frame-latched position, hotspot, clipping and blink.
module draw_cursor #(
  parameter int SPRITE_W     = 16,
  parameter int SPRITE_H     = 16,
  parameter int NUM_SHAPES   = 4,
  parameter int HOT_X        = 0,
  parameter int HOT_Y        = 0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [11:0]                   x_pos,
  input  logic [11:0]                   y_pos,
  input  logic                          cursor_en,
  input  logic [$clog2(NUM_SHAPES)-1:0] shape_sel,
  input  logic                          blink_en,
  input  logic [11:0]                   color_a,
  input  logic [11:0]                   color_b,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_SHAPES)-1:0] wr_shape,
  input  logic [$clog2(SPRITE_H)-1:0]   wr_row,
  input  logic [2*SPRITE_W-1:0]         wr_data,
  vga_if.in                             in,
  vga_if.out                            out
);
  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = $clog2(SPRITE_H);
  localparam int SW = $clog2(NUM_SHAPES);
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] CMAX = BW'(BLINK_FRAMES - 1);
  localparam logic signed [13:0] WL = 14'(SPRITE_W);
  localparam logic signed [13:0] HL = 14'(SPRITE_H);

  logic [2*SPRITE_W-1:0] mem [NUM_SHAPES][SPRITE_H];
  logic [2*SPRITE_W-1:0] row_q;
  logic [11:0]           x_lat, y_lat;
  logic [SW-1:0]         shape_lat;
  logic                  en_lat, vb_prev, phase;
  logic [BW-1:0]         cnt;
  logic signed [13:0]    dx, dy;
  logic                  in_x, in_y, hit, fs;
  logic [RW-1:0]         rd_row;
  logic [CW-1:0]         col_q;
  logic                  hit_q, hs_q, vs_q, hb_q, vb_q;
  logic [11:0]           hc_q, vc_q, rgb_q, pix;
  logic [1:0]            code;

  // 14-bit offsets keep the hit test free of wrap-around at either screen edge
  always_comb begin
    fs     = in.vblnk & ~vb_prev;
    dx     = {2'b00, in.hcount} - {2'b00, x_lat} + 14'(HOT_X);
    dy     = {2'b00, in.vcount} - {2'b00, y_lat} + 14'(HOT_Y);
    in_x   = dx >= 14'sd0 && dx < WL;
    in_y   = dy >= 14'sd0 && dy < HL;
    rd_row = in_y ? dy[RW-1:0] : '0;
    hit    = in_x && in_y && !in.hblnk && !in.vblnk && en_lat && (!blink_en || phase);
    code   = row_q[{col_q, 1'b0} +: 2];
    pix    = code == 2'b01 ? color_a :
             code == 2'b10 ? color_b :
             code == 2'b11 ? rgb_q ^ 12'hFFF : rgb_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en && 32'(wr_row) < SPRITE_H) mem[wr_shape][wr_row] <= wr_data;
    row_q <= mem[shape_lat][rd_row];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_lat      <= '0;
      y_lat      <= '0;
      shape_lat  <= '0;
      en_lat     <= 1'b0;
      vb_prev    <= 1'b0;
      cnt        <= '0;
      phase      <= 1'b1;
      col_q      <= '0;
      hit_q      <= 1'b0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      hb_q       <= 1'b0;
      vb_q       <= 1'b0;
      hc_q       <= '0;
      vc_q       <= '0;
      rgb_q      <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hcount <= '0;
      out.vcount <= '0;
      out.rgb    <= '0;
    end else begin
      vb_prev <= in.vblnk;
      if (fs) begin
        x_lat     <= x_pos;
        y_lat     <= y_pos;
        shape_lat <= shape_sel;
        en_lat    <= cursor_en;
        cnt       <= cnt == CMAX ? '0 : cnt + 1'b1;
        if (cnt == CMAX) phase <= ~phase;
      end
      col_q      <= dx[CW-1:0];
      hit_q      <= hit;
      hs_q       <= in.hsync;
      vs_q       <= in.vsync;
      hb_q       <= in.hblnk;
      vb_q       <= in.vblnk;
      hc_q       <= in.hcount;
      vc_q       <= in.vcount;
      rgb_q      <= in.rgb;
      out.hsync  <= hs_q;
      out.vsync  <= vs_q;
      out.hblnk  <= hb_q;
      out.vblnk  <= vb_q;
      out.hcount <= hc_q;
      out.vcount <= vc_q;
      out.rgb    <= hit_q ? pix : rgb_q;
    end
  end
endmodule

// File: tb/tb_draw_cursor.sv
// tb_draw_cursor: random raster with a frame-level cursor model feeding a scoreboard queue.
module tb_draw_cursor;
  localparam int W = 8, H = 6, NS = 4, HX = 3, HY = 2, BF = 2, WD = 2 * W;
  localparam int H_ACT = 40, H_TOT = 48, V_ACT = 24, V_TOT = 28, FR = H_TOT * V_TOT;
  localparam int RST_AT = 20 * FR + 10 * H_TOT + 20;

  typedef struct packed {
    logic hs, vs, hb, vb;
    logic [11:0] hc, vc, rgb;
  } exp_t;

  logic clk = 0, rst_n = 0;
  logic [11:0] x_pos = 0, y_pos = 0, color_a = 0, color_b = 0;
  logic cursor_en = 0, blink_en = 1, wr_en = 0;
  logic [1:0] shape_sel = 0, wr_shape = 0;
  logic [2:0] wr_row = 0;
  logic [WD-1:0] wr_data = 0;

  vga_if vin();
  vga_if vout();

  draw_cursor #(.SPRITE_W(W), .SPRITE_H(H), .NUM_SHAPES(NS), .HOT_X(HX), .HOT_Y(HY),
                .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .x_pos(x_pos), .y_pos(y_pos), .cursor_en(cursor_en),
    .shape_sel(shape_sel), .blink_en(blink_en), .color_a(color_a), .color_b(color_b),
    .wr_en(wr_en), .wr_shape(wr_shape), .wr_row(wr_row), .wr_data(wr_data),
    .in(vin), .out(vout));

  always #5 clk = ~clk;

  exp_t q[$];
  int total = 0, bad = 0, hits = 0, hc = 0, vc = 0, frames = 0, x_l = 0, y_l = 0, sh_l = 0;
  bit en_l = 0, prev_vb = 0, mon_on = 0;
  logic [WD-1:0] m_mem [NS][H];

  function automatic exp_t got();
    return {vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.hcount, vout.vcount, vout.rgb};
  endfunction

  function automatic logic [11:0] pick(input int lim);
    return ($urandom_range(0, 9) == 0) ? 12'(4095 - $urandom_range(0, 3)) : 12'($urandom_range(0, lim));
  endfunction

  task automatic new_ctrl();
    x_pos = pick(H_TOT);
    y_pos = pick(V_TOT);
    shape_sel = 2'($urandom_range(0, NS - 1));
    cursor_en = $urandom_range(0, 5) != 0;
  endtask

  task automatic zero_check(input string name);
    total++;
    if (got() !== 40'h0) begin
      bad++;
      $display("FAIL %s got=%h want=0", name, got());
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_on && q.size() > 2) begin
      e = q.pop_front();
      total++;
      if (got() !== e) begin
        bad++;
        $display("FAIL pixel hc=%0d vc=%0d got=%h want=%h", e.hc, e.vc, got(), e);
      end
    end
  end

  task automatic step(input bit rel);
    logic [11:0] rgb;
    int col, row, code;
    bit hb, vb, hit;
    exp_t e;
    @(posedge clk);
    #1;
    if (rel) begin
      rst_n = 1;
      q.push_back('0);
      q.push_back('0);
      mon_on = 1;
    end
    hb = hc >= H_ACT;
    vb = vc >= V_ACT;
    rgb = 12'($urandom);
    vin.hcount = 12'(hc);
    vin.vcount = 12'(vc);
    vin.hblnk = hb;
    vin.vblnk = vb;
    vin.hsync = hc >= H_ACT + 2 && hc < H_ACT + 6;
    vin.vsync = vc == V_ACT + 1;
    vin.rgb = rgb;
    if ((vc == V_ACT && hc == 0) || $urandom_range(0, 299) == 0) new_ctrl();
    if ($urandom_range(0, 1999) == 0) blink_en = ~blink_en;
    if (vc == V_ACT + 1 && hc == 0) begin
      color_a = 12'($urandom);
      color_b = 12'($urandom);
    end
    wr_en = $urandom_range(0, 7) == 0;
    wr_shape = 2'($urandom_range(0, NS - 1));
    wr_row = 3'($urandom_range(0, H - 1));
    wr_data = WD'($urandom);
    if (rst_n) begin
      if (vb && !prev_vb) begin
        x_l = int'(x_pos);
        y_l = int'(y_pos);
        sh_l = int'(shape_sel);
        en_l = cursor_en;
        frames++;
      end
      prev_vb = vb;
      col = hc - (x_l - HX);
      row = vc - (y_l - HY);
      hit = !hb && !vb && en_l && (!blink_en || (frames / BF) % 2 == 0) &&
            col >= 0 && col < W && row >= 0 && row < H;
      code = 0;
      if (hit) code = int'(m_mem[sh_l][row][2*col +: 2]);
      if (code != 0) hits++;
      e.hs = vin.hsync;
      e.vs = vin.vsync;
      e.hb = hb;
      e.vb = vb;
      e.hc = 12'(hc);
      e.vc = 12'(vc);
      e.rgb = code == 1 ? color_a : code == 2 ? color_b : code == 3 ? rgb ^ 12'hFFF : rgb;
      q.push_back(e);
    end
    if (wr_en) m_mem[wr_shape][wr_row] = wr_data;
    hc++;
    if (hc == H_TOT) begin
      hc = 0;
      vc = (vc + 1) % V_TOT;
    end
  endtask

  task automatic mid_reset();
    @(posedge clk);
    mon_on = 0;
    q.delete();
    #3 rst_n = 0;
    #1 zero_check("async_rst");
    frames = 0;
    en_l = 0;
    prev_vb = 0;
  endtask

  initial begin
    vin.hsync = 0; vin.vsync = 0; vin.hblnk = 0; vin.vblnk = 0;
    vin.hcount = 0; vin.vcount = 0; vin.rgb = 0;
    repeat (3) @(posedge clk);
    #1 zero_check("rst_init");
    for (int s = 0; s < NS; s++)
      for (int r = 0; r < H; r++) begin
        @(posedge clk);
        #1;
        wr_en = 1;
        wr_shape = 2'(s);
        wr_row = 3'(r);
        wr_data = WD'($urandom);
        m_mem[s][r] = wr_data;
      end
    new_ctrl();
    cursor_en = 1;
    step(1);
    for (int i = 0; i < 34 * FR; i++) begin
      if (i == RST_AT) begin
        mid_reset();
        repeat (5) step(0);
        step(1);
      end else step(0);
    end
    repeat (4) @(posedge clk);
    total++;
    if (hits < 50) begin
      bad++;
      $display("FAIL drawn_pixels got=%0d want>=50", hits);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
